arvi_mem_responder: RTL and testbench
=====================================

# arvi_mem_responder

Memory-side responder for the ARVI core's two memory handshakes: instruction fetch (`I_CACHE` refill) and data access (`DATA_MEMORY_V2`). One word-wide RAM serves both ports through a fixed-priority arbiter. A configurable latency counter and a one-cycle ready pulse stand in for real memory in simulation and FPGA builds. The block sits outside `DATAPATH_SC` and connects port-for-port to its `o_IC_*`/`o_IM_*` and `o_DM_*`/`i_DM_*` signals.

## Interface
- `DEPTH`, 1024: RAM size in `XLEN`-bit words; power of two. `AW = $clog2(DEPTH)`.
- `LATENCY`, 2: cycles from request acceptance to ready pulse; legal range 1..15.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst`  in  1  reset; synchronous, active-high.
- `i_IC_DataReq`  in  1  instruction-fetch request (level).
- `i_IM_Addr`  in  `XLEN`  fetch byte address.
- `o_IM_Instr`  out  `XLEN`  fetched word.
- `o_IC_MemReady`  out  1  fetch-complete pulse.
- `i_DM_MemRead`  in  1  data read request (level).
- `i_DM_Wen`  in  1  data write request (level).
- `i_DM_Addr`  in  `XLEN`  data byte address.
- `i_DM_Wd`  in  `XLEN`  store data, right-aligned.
- `i_DM_f3`  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `o_DM_ReadData`  out  `XLEN`  load data, right-aligned and extended.
- `o_DM_data_ready`  out  1  data-access-complete pulse.

## Operation
- FSM states: `IDLE`, `IBUSY`, `DBUSY`. The 4-bit latency counter `cnt` resets to 0.
- Acceptance happens only in `IDLE`:
  - A data request (`i_DM_MemRead | i_DM_Wen`) has priority over `i_IC_DataReq`.
  - Accepting a request latches the address, f3, write data and request kind, sets `cnt = 1`, and moves to the matching BUSY state.
  - If both `i_DM_Wen` and `i_DM_MemRead` are high, the access is a write.
- In BUSY, `cnt` increments each cycle.
  - When `cnt == LATENCY`, the port's ready output is high for that one cycle. The FSM returns to `IDLE` at the next edge.
  - The port's request in the cycle after ready is treated as a new request.
- RAM index is `addr[AW+1:2]`. Higher address bits are ignored, so the address space wraps modulo `4*DEPTH` bytes.
- Fetch: `o_IM_Instr` = the full word, valid in the ready cycle and held until the next fetch completes. `i_IM_Addr[1:0]` is ignored.
- Data writes: byte enables come from f3 and `addr[1:0]`:
  - SB writes lane `addr[1:0]`.
  - SH writes lanes {`addr[1]*2`, `+1`}.
  - SW writes all four lanes.
  - Data is taken from the low bits of `i_DM_Wd` and shifted into the lanes.
  - The RAM updates at the edge that ends the ready cycle.
- Data reads: the lane is selected the same way, then sign-extended for B/H or zero-extended for BU/HU/W. Data is valid in the ready cycle and held until the next data read completes. Writes leave `o_DM_ReadData` unchanged.
- Misaligned access (H/HU with `addr[0]=1`, W with `addr[1:0]!=0`) still completes normally with a ready pulse. Misaligned writes change no RAM byte; misaligned reads return 0.
- An undefined f3 (011, 11x) is treated as W.

## Timing
- Reset values: `o_IC_MemReady=0`, `o_DM_data_ready=0`, `o_IM_Instr=0`, `o_DM_ReadData=0`; FSM in `IDLE`; `cnt=0`. RAM contents are not cleared.
- Latency: a request accepted at edge T gives ready high in cycle T+`LATENCY`-1 after that edge, i.e. `LATENCY` cycles after the request was first seen in `IDLE`.
- Back-to-back throughput: one access per `LATENCY`+1 cycles per arbiter (one `IDLE` cycle between accesses).
- Simultaneous fetch and data requests in `IDLE`: data is served first, then fetch once the data ready cycle ends.
- Request inputs are sampled only at acceptance. Changes during BUSY are ignored. A dropped request still completes.
- Reset during BUSY: the FSM aborts to `IDLE`, a pending write is discarded, and no ready pulse is issued.

## Configuration
- `ARVI_MEM_MISALIGN_EX_EN` defined:
  - Adds port `o_DM_err  out  1`, reset 0. It is high in the data ready cycle of a misaligned access, low otherwise.
  - In this mode a misaligned read returns the aligned word unmodified instead of 0.
- Undefined: no `o_DM_err` port; misaligned behaviour is as described under Operation.

## Test plan
- Reset with `LATENCY=2`, preload word 0x10 = 0xDEADBEEF, fetch `i_IM_Addr=0x40` -> `o_IC_MemReady` pulses exactly one cycle, 2 cycles after the request, with `o_IM_Instr=0xDEADBEEF`.
- SB 0xA5 to 0x41, then LB 0x41 -> read gives 0xFFFFFFA5; LBU 0x41 -> 0x000000A5; LW 0x40 -> 0xDEADA5EF.
- Fetch and load requested in the same `IDLE` cycle -> `o_DM_data_ready` pulses first, then one `IDLE` cycle, then `o_IC_MemReady` 2 cycles later.
- SH to 0x43 (misaligned) with 0x1234 -> ready pulses; word 0x40 unchanged; with macro, `o_DM_err=1` in the ready cycle.
- `i_rst` asserted mid-write in `DBUSY` -> no ready pulse, outputs 0, target word unchanged.
- `DEPTH=1024`, LW at 0x1000 -> returns word 0 (wrap-around).

Source files
------------

// File: rtl/arvi_mem_responder.sv
// -----------------------------------------------------------------------------
// arvi_mem_responder
//
// Memory-side responder for the ARVI core. One word-wide RAM serves both the
// instruction-fetch handshake (I_CACHE refill) and the data handshake
// (DATA_MEMORY_V2) through a fixed-priority arbiter: data wins over fetch.
// A latency counter plus a one-cycle ready pulse model a slow memory.
//
// Parameters
//   DEPTH    RAM size in 32-bit words (power of two)
//   LATENCY  cycles from acceptance to ready pulse (1..15)
//
// Ports
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_IC_DataReq       fetch request (level)
//   i_IM_Addr          fetch byte address
//   o_IM_Instr         fetched word (valid in ready cycle, then held)
//   o_IC_MemReady      fetch-complete pulse
//   i_DM_MemRead       data read request (level)
//   i_DM_Wen           data write request (level, wins over read)
//   i_DM_Addr          data byte address
//   i_DM_Wd            store data, right-aligned
//   i_DM_f3            access size/sign (B/H/W/BU/HU; others act as W)
//   o_DM_ReadData      load data (valid in ready cycle, then held)
//   o_DM_data_ready    data-access-complete pulse
//   o_DM_err           misaligned-access flag (only with the macro below)
//
// Optional feature macro: ARVI_MEM_MISALIGN_EX_EN
//   Adds o_DM_err, and misaligned reads return the raw aligned word.
// -----------------------------------------------------------------------------
module arvi_mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_IC_DataReq,
  input  logic [31:0] i_IM_Addr,
  output logic [31:0] o_IM_Instr,
  output logic        o_IC_MemReady,
  input  logic        i_DM_MemRead,
  input  logic        i_DM_Wen,
  input  logic [31:0] i_DM_Addr,
  input  logic [31:0] i_DM_Wd,
  input  logic [2:0]  i_DM_f3,
  output logic [31:0] o_DM_ReadData,
`ifdef ARVI_MEM_MISALIGN_EX_EN
  output logic        o_DM_err,
`endif
  output logic        o_DM_data_ready
);

  localparam int XLEN = 32;
  localparam int AW   = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_IBUSY = 2'd1;
  localparam logic [1:0] S_DBUSY = 2'd2;

  localparam logic [3:0] LAT4 = 4'(LATENCY);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]      r_state;
  logic [3:0]      r_cnt;
  logic [AW+1:0]   r_addr;   // only the bits that index the RAM and the lane
  logic [2:0]      r_f3;
  logic [XLEN-1:0] r_wd;
  logic            r_wen;
  logic [XLEN-1:0] r_word;   // RAM word snapshot taken at acceptance
  logic [XLEN-1:0] r_instr;  // held fetch result
  logic [XLEN-1:0] r_rdata;  // held load result

  logic [XLEN-1:0] r_mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Arbitration / handshake
  // ---------------------------------------------------------------------------
  logic          w_dreq;
  logic          w_acc_d;
  logic          w_acc_i;
  logic [AW+1:0] w_acc_addr;
  logic          w_done;
  logic          w_ic_ready;
  logic          w_d_ready;

  assign w_dreq     = i_DM_MemRead | i_DM_Wen;
  assign w_acc_d    = (r_state == S_IDLE) & w_dreq;
  assign w_acc_i    = (r_state == S_IDLE) & ~w_dreq & i_IC_DataReq;
  assign w_acc_addr = w_dreq ? i_DM_Addr[AW+1:0] : i_IM_Addr[AW+1:0];

  // Ready is suppressed while reset is asserted so an aborted access never
  // pulses, even if reset lands exactly on the ready cycle.
  assign w_done     = (r_state != S_IDLE) && (r_cnt == LAT4);
  assign w_ic_ready = w_done && (r_state == S_IBUSY) && !i_rst;
  assign w_d_ready  = w_done && (r_state == S_DBUSY) && !i_rst;

  // ---------------------------------------------------------------------------
  // Size / lane decode. f3[1] set means word (covers W and the undefined
  // encodings 011, 11x); otherwise f3[0] picks half vs byte, f3[2] = unsigned.
  // ---------------------------------------------------------------------------
  logic            w_is_w;
  logic            w_is_h;
  logic            w_misal;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wshift;
  logic [XLEN-1:0] w_lane;
  logic [XLEN-1:0] w_ld_data;

  assign w_is_w  = r_f3[1];
  assign w_is_h  = ~r_f3[1] & r_f3[0];
  assign w_misal = (w_is_h & r_addr[0]) | (w_is_w & (|r_addr[1:0]));

  // Store data is right-aligned; shifting by the byte offset lands it in the
  // addressed lanes for every aligned size (H offsets are 0/2, W offset 0).
  assign w_wshift = r_wd << {r_addr[1:0], 3'b000};
  assign w_lane   = r_word >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_be = 4'b0000;
    if (!w_misal) begin
      if (w_is_w)      w_be = 4'b1111;
      else if (w_is_h) w_be = 4'b0011 << {r_addr[1], 1'b0};
      else             w_be = 4'b0001 << r_addr[1:0];
    end
  end

  always_comb begin
    w_ld_data = '0;
    if (w_misal) begin
`ifdef ARVI_MEM_MISALIGN_EX_EN
      w_ld_data = r_word;
`else
      w_ld_data = '0;
`endif
    end else if (w_is_w) begin
      w_ld_data = r_word;
    end else if (w_is_h) begin
      w_ld_data = {{16{~r_f3[2] & w_lane[15]}}, w_lane[15:0]};
    end else begin
      w_ld_data = {{24{~r_f3[2] & w_lane[7]}}, w_lane[7:0]};
    end
  end

  // ---------------------------------------------------------------------------
  // FSM, counter and held outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_instr <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_acc_d) begin
            r_state <= S_DBUSY;
            r_cnt   <= 4'd1;
          end else if (w_acc_i) begin
            r_state <= S_IBUSY;
            r_cnt   <= 4'd1;
          end
        end
        default: begin
          if (w_done) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
      endcase
      if (w_ic_ready)            r_instr <= r_word;
      if (w_d_ready && !r_wen)   r_rdata <= w_ld_data;
    end
  end

  // Request capture. Inputs are only looked at here, so anything the core
  // does to them during BUSY is ignored.
  always_ff @(posedge i_clk) begin
    if (w_acc_d || w_acc_i) begin
      r_addr <= w_acc_addr;
      r_word <= r_mem[w_acc_addr[AW+1:2]];
    end
    if (w_acc_d) begin
      r_f3  <= i_DM_f3;
      r_wd  <= i_DM_Wd;
      r_wen <= i_DM_Wen;
    end
  end

  // RAM byte writes commit at the edge that closes the ready cycle; an
  // aborted write never reaches here because w_d_ready is gated by reset.
  always_ff @(posedge i_clk) begin
    if (w_d_ready && r_wen) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[r_addr[AW+1:2]][8*b +: 8] <= w_wshift[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: fresh data in the ready cycle, held copy otherwise
  // ---------------------------------------------------------------------------
  assign o_IC_MemReady   = w_ic_ready;
  assign o_DM_data_ready = w_d_ready;
  assign o_IM_Instr      = w_ic_ready ? r_word : r_instr;
  assign o_DM_ReadData   = (w_d_ready && !r_wen) ? w_ld_data : r_rdata;

`ifdef ARVI_MEM_MISALIGN_EX_EN
  assign o_DM_err = w_d_ready & w_misal;
`endif

  // Address bits above the RAM window are ignored (wrap-around).
  logic w_unused_addr;
  assign w_unused_addr = ^{i_IM_Addr[31:AW+2], i_DM_Addr[31:AW+2]};

endmodule

// File: tb/tb_arvi_mem_responder.sv
module tb_arvi_mem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_IC_DataReq;
  logic [31:0] i_IM_Addr;
  logic [31:0] o_IM_Instr;
  logic        o_IC_MemReady;
  logic        i_DM_MemRead;
  logic        i_DM_Wen;
  logic [31:0] i_DM_Addr;
  logic [31:0] i_DM_Wd;
  logic [2:0]  i_DM_f3;
  logic [31:0] o_DM_ReadData;
  logic        o_DM_data_ready;
  logic        dut_err;

  always #5 clk = ~clk;

  arvi_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_IC_DataReq(i_IC_DataReq), .i_IM_Addr(i_IM_Addr),
    .o_IM_Instr(o_IM_Instr), .o_IC_MemReady(o_IC_MemReady),
    .i_DM_MemRead(i_DM_MemRead), .i_DM_Wen(i_DM_Wen),
    .i_DM_Addr(i_DM_Addr), .i_DM_Wd(i_DM_Wd), .i_DM_f3(i_DM_f3),
    .o_DM_ReadData(o_DM_ReadData),
`ifdef ARVI_MEM_MISALIGN_EX_EN
    .o_DM_err(dut_err),
`endif
    .o_DM_data_ready(o_DM_data_ready)
  );

`ifdef ARVI_MEM_MISALIGN_EX_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
  assign dut_err = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference memory: one 32-bit word per RAM index
  logic [31:0] mm [DEPTH];

  function automatic int sz_of(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  function automatic bit m_misal(input logic [31:0] a, input logic [2:0] f3);
    return ((a % 4) % sz_of(f3)) != 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] f3);
    int sz, off;
    logic [31:0] w, v;
    sz  = sz_of(f3);
    off = int'(a % 4);
    w   = mm[(a / 4) % DEPTH];
    if (m_misal(a, f3)) return MIS ? w : 32'd0;
    v = w >> (8 * off);
    if (sz == 1) begin
      v = v & 32'hFF;
      if (f3 == 3'b000 && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else if (sz == 2) begin
      v = v & 32'hFFFF;
      if (f3 == 3'b001 && v >= 32'h8000) v = v | 32'hFFFF0000;
    end
    return v;
  endfunction

  task automatic m_store(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3);
    int sz, off, idx;
    logic [31:0] w;
    if (m_misal(a, f3)) return;
    sz  = sz_of(f3);
    off = int'(a % 4);
    idx = int'((a / 4) % DEPTH);
    w   = mm[idx];
    for (int b = 0; b < sz; b++) begin
      w[8*(off+b) +: 8] = wd[8*b +: 8];
    end
    mm[idx] = w;
  endtask

  // Stimulus drivers: start in an IDLE cycle at a negedge, end at the negedge
  // of the cycle after the ready pulse (the next IDLE cycle).
  task automatic data_acc(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] f3, output logic [31:0] rd,
                          output int lat, output bit pulse1, output bit err);
    i_DM_Wen = wr; i_DM_MemRead = ~wr; i_DM_Addr = a; i_DM_Wd = wd; i_DM_f3 = f3;
    lat = 0; rd = '0; err = 1'b0; pulse1 = 1'b0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge clk);
      if (i == 1) begin
        // drop the request and scramble the operands: must be ignored now
        i_DM_Wen = 1'b0; i_DM_MemRead = 1'b0;
        i_DM_Addr = $urandom; i_DM_Wd = $urandom; i_DM_f3 = 3'($urandom);
      end
      if (o_DM_data_ready) begin lat = i; rd = o_DM_ReadData; err = dut_err; end
    end
    @(negedge clk);
    pulse1 = !o_DM_data_ready;
  endtask

  task automatic fetch_acc(input logic [31:0] a, output logic [31:0] ins,
                           output int lat, output bit pulse1);
    i_IC_DataReq = 1'b1; i_IM_Addr = a;
    lat = 0; ins = '0; pulse1 = 1'b0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge clk);
      if (i == 1) begin i_IC_DataReq = 1'b0; i_IM_Addr = $urandom; end
      if (o_IC_MemReady) begin lat = i; ins = o_IM_Instr; end
    end
    @(negedge clk);
    pulse1 = !o_IC_MemReady;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_IC_DataReq = 0; i_IM_Addr = 0; i_DM_MemRead = 0; i_DM_Wen = 0;
    i_DM_Addr = 0; i_DM_Wd = 0; i_DM_f3 = 0;
    repeat (3) @(negedge clk);
    i_rst = 1'b0;
    @(negedge clk);
    checks++; if (o_IC_MemReady !== 1'b0) begin failures++; $display("FAIL reset_ic_ready got=%b exp=0", o_IC_MemReady); end
    checks++; if (o_DM_data_ready !== 1'b0) begin failures++; $display("FAIL reset_dm_ready got=%b exp=0", o_DM_data_ready); end
    checks++; if (o_IM_Instr !== 32'd0) begin failures++; $display("FAIL reset_instr got=%h exp=0", o_IM_Instr); end
    checks++; if (o_DM_ReadData !== 32'd0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", o_DM_ReadData); end
    checks++; if (dut_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", dut_err); end
  endtask

  task automatic test_fetch();
    logic [31:0] rd; int lat; bit p1, err;
    data_acc(1'b1, 32'h40, 32'hDEADBEEF, 3'b010, rd, lat, p1, err);
    m_store(32'h40, 32'hDEADBEEF, 3'b010);
    checks++; if (lat != LAT) begin failures++; $display("FAIL sw_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (o_DM_ReadData !== 32'd0) begin failures++; $display("FAIL sw_keeps_rdata got=%h exp=0", o_DM_ReadData); end
    fetch_acc(32'h40, rd, lat, p1);
    checks++; if (lat != LAT) begin failures++; $display("FAIL fetch_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (!p1) begin failures++; $display("FAIL fetch_pulse_width got=2+ exp=1"); end
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL fetch_data got=%h exp=deadbeef", rd); end
    checks++; if (o_IM_Instr !== 32'hDEADBEEF) begin failures++; $display("FAIL fetch_hold got=%h exp=deadbeef", o_IM_Instr); end
  endtask

  task automatic test_byte();
    logic [31:0] rd; int lat; bit p1, err;
    data_acc(1'b1, 32'h41, 32'h123456A5, 3'b000, rd, lat, p1, err);
    m_store(32'h41, 32'h123456A5, 3'b000);
    data_acc(1'b0, 32'h41, 32'h0, 3'b000, rd, lat, p1, err);
    checks++; if (rd !== 32'hFFFFFFA5) begin failures++; $display("FAIL lb got=%h exp=ffffffa5", rd); end
    checks++; if (!p1) begin failures++; $display("FAIL lb_pulse_width got=2+ exp=1"); end
    data_acc(1'b0, 32'h41, 32'h0, 3'b100, rd, lat, p1, err);
    checks++; if (rd !== 32'h000000A5) begin failures++; $display("FAIL lbu got=%h exp=000000a5", rd); end
    data_acc(1'b0, 32'h40, 32'h0, 3'b010, rd, lat, p1, err);
    checks++; if (rd !== 32'hDEADA5EF) begin failures++; $display("FAIL lw got=%h exp=deada5ef", rd); end
    checks++; if (o_DM_ReadData !== 32'hDEADA5EF) begin failures++; $display("FAIL load_hold got=%h exp=deada5ef", o_DM_ReadData); end
  endtask

  task automatic test_priority();
    int d_at, i_at;
    logic [31:0] d_val, i_val;
    d_at = 0; i_at = 0; d_val = '0; i_val = '0;
    i_DM_MemRead = 1'b1; i_DM_Addr = 32'h42; i_DM_f3 = 3'b101;
    i_IC_DataReq = 1'b1; i_IM_Addr = 32'h40;
    for (int i = 1; i <= 30 && i_at == 0; i++) begin
      @(negedge clk);
      if (i == 1) i_DM_MemRead = 1'b0;
      if (o_DM_data_ready && d_at == 0) begin d_at = i; d_val = o_DM_ReadData; end
      if (o_IC_MemReady) begin i_at = i; i_val = o_IM_Instr; end
      if (d_at != 0 && i == d_at + 2) i_IC_DataReq = 1'b0;
    end
    i_IC_DataReq = 1'b0;
    @(negedge clk);
    checks++; if (d_at != LAT) begin failures++; $display("FAIL prio_data_first got=%0d exp=%0d", d_at, LAT); end
    checks++; if (i_at != 2 * LAT + 1) begin failures++; $display("FAIL prio_fetch_after got=%0d exp=%0d", i_at, 2 * LAT + 1); end
    checks++; if (d_val !== m_load(32'h42, 3'b101)) begin failures++; $display("FAIL prio_lhu got=%h exp=%h", d_val, m_load(32'h42, 3'b101)); end
    checks++; if (i_val !== mm[16]) begin failures++; $display("FAIL prio_fetch_data got=%h exp=%h", i_val, mm[16]); end
  endtask

  task automatic test_misalign();
    logic [31:0] rd; int lat; bit p1, err;
    data_acc(1'b1, 32'h43, 32'h1234, 3'b001, rd, lat, p1, err);
    checks++; if (lat != LAT) begin failures++; $display("FAIL mis_sh_ready got=%0d exp=%0d", lat, LAT); end
    checks++; if (err !== MIS) begin failures++; $display("FAIL mis_sh_err got=%b exp=%b", err, MIS); end
    data_acc(1'b0, 32'h40, 32'h0, 3'b010, rd, lat, p1, err);
    checks++; if (rd !== 32'hDEADA5EF) begin failures++; $display("FAIL mis_sh_unchanged got=%h exp=deada5ef", rd); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL aligned_err got=%b exp=0", err); end
    data_acc(1'b0, 32'h42, 32'h0, 3'b010, rd, lat, p1, err);
    checks++; if (rd !== (MIS ? 32'hDEADA5EF : 32'd0)) begin failures++; $display("FAIL mis_lw got=%h exp=%h", rd, MIS ? 32'hDEADA5EF : 32'd0); end
    checks++; if (err !== MIS) begin failures++; $display("FAIL mis_lw_err got=%b exp=%b", err, MIS); end
  endtask

  task automatic test_wrap();
    logic [31:0] rd, v; int lat; bit p1, err;
    v = $urandom;
    data_acc(1'b1, 32'h0, v, 3'b010, rd, lat, p1, err);
    m_store(32'h0, v, 3'b010);
    data_acc(1'b0, 32'h1000, 32'h0, 3'b010, rd, lat, p1, err);
    checks++; if (rd !== v) begin failures++; $display("FAIL wrap_lw got=%h exp=%h", rd, v); end
  endtask

  task automatic test_reset_busy();
    logic [31:0] rd, v; int lat; bit p1, err, seen;
    v = $urandom;
    data_acc(1'b1, 32'h48, v, 3'b010, rd, lat, p1, err);
    m_store(32'h48, v, 3'b010);
    i_DM_Wen = 1'b1; i_DM_Addr = 32'h48; i_DM_Wd = ~v; i_DM_f3 = 3'b010;
    @(negedge clk);
    i_DM_Wen = 1'b0; i_rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (o_DM_data_ready) seen = 1'b1;
    end
    i_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (o_DM_data_ready) seen = 1'b1;
    end
    checks++; if (seen) begin failures++; $display("FAIL rst_busy_no_ready got=1 exp=0"); end
    checks++; if (o_IM_Instr !== 32'd0) begin failures++; $display("FAIL rst_busy_instr got=%h exp=0", o_IM_Instr); end
    checks++; if (o_DM_ReadData !== 32'd0) begin failures++; $display("FAIL rst_busy_rdata got=%h exp=0", o_DM_ReadData); end
    data_acc(1'b0, 32'h48, 32'h0, 3'b010, rd, lat, p1, err);
    checks++; if (rd !== v) begin failures++; $display("FAIL rst_busy_word got=%h exp=%h", rd, v); end
  endtask

  task automatic test_random();
    logic [31:0] rd, a, wd, exp; int lat; bit p1, err; int kind; logic [2:0] f3;
    for (int w = 0; w < 32; w++) begin
      wd = $urandom;
      data_acc(1'b1, 32'(w * 4), wd, 3'b010, rd, lat, p1, err);
      m_store(32'(w * 4), wd, 3'b010);
    end
    for (int n = 0; n < 250; n++) begin
      kind = $urandom_range(0, 2);
      a  = {20'($urandom), 5'($urandom), 2'($urandom), 5'd0} | 32'($urandom_range(0, 127));
      a  = {a[31:12], 5'd0, a[6:0]};
      wd = $urandom;
      f3 = 3'($urandom);
      if (kind == 0) begin
        data_acc(1'b1, a, wd, f3, rd, lat, p1, err);
        m_store(a, wd, f3);
      end else if (kind == 1) begin
        data_acc(1'b0, a, 32'h0, f3, rd, lat, p1, err);
        exp = m_load(a, f3);
        checks++; if (rd !== exp) begin failures++; $display("FAIL rnd_load a=%h f3=%0d got=%h exp=%h", a, f3, rd, exp); end
      end else begin
        fetch_acc(a, rd, lat, p1);
        exp = mm[(a / 4) % DEPTH];
        checks++; if (rd !== exp) begin failures++; $display("FAIL rnd_fetch a=%h got=%h exp=%h", a, rd, exp); end
      end
      checks++; if (lat != LAT || !p1) begin failures++; $display("FAIL rnd_timing op=%0d got_lat=%0d single=%b exp_lat=%0d", kind, lat, p1, LAT); end
      if (kind != 2) begin
        checks++; if (err !== (MIS & m_misal(a, f3))) begin failures++; $display("FAIL rnd_err a=%h f3=%0d got=%b exp=%b", a, f3, err, MIS & m_misal(a, f3)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_byte();
    test_priority();
    test_misalign();
    test_wrap();
    test_reset_busy();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
